// File: rtl/prng_sched_pkg.sv
// Shared types and defaults for the Lehmer PRNG scheduler.
// Holds the FSM state encoding, the default generator constants and the watchdog sizing helper.
package prng_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_START   = 3'd2,
        S_RELEASE = 3'd3,
        S_DELIVER = 3'd4
    } state_e;

    localparam logic [31:0] DEF_INIT_SEED = 32'd1;
    localparam logic [31:0] DEF_MULT_A    = 32'd16807;
    localparam logic [31:0] DEF_MOD_M     = 32'h7FFFFFFF;
    localparam int          DEF_TIMEOUT   = 1024;

    function automatic int wd_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping, as one-hot plus index.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/prng_scheduler.sv
// Arbitrates NREQ requesters onto one Lehmer core, chaining every result back in as the next seed.
// Includes a watchdog on the core handshake and deferred seed loading while a draw is in flight.
module prng_scheduler
    import prng_sched_pkg::*;
#(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] INIT_SEED = WIDTH'(DEF_INIT_SEED),
    parameter logic [WIDTH-1:0] MULT_A    = WIDTH'(DEF_MULT_A),
    parameter logic [WIDTH-1:0] MOD_M     = WIDTH'(DEF_MOD_M),
    parameter int               TIMEOUT   = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    output logic [WIDTH-1:0] rnd_out,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             busy,
    output logic             timeout_err,
    output logic [WIDTH-1:0] prng_m,
    output logic [WIDTH-1:0] prng_a,
    output logic [WIDTH-1:0] prng_seed,
    output logic             prng_start,
    output logic             prng_cont,
    input  logic             prng_done,
    input  logic [WIDTH-1:0] prng_rand
);

    localparam int              PTR_W   = (NREQ < 2) ? 1 : $clog2(NREQ);
    localparam int              WD_W    = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_idx_q, win_idx_d;
    logic [NREQ-1:0]  win_oh_q, win_oh_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             err_q, err_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic [NREQ-1:0]  pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic             wd_expired;

    // Zero is a fixed point of the generator and values >= m are outside its range.
    function automatic logic [WIDTH-1:0] sanitize_seed(input logic [WIDTH-1:0] v);
        return (v == '0 || v >= MOD_M) ? {{(WIDTH-1){1'b0}}, 1'b1} : v;
    endfunction

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign wd_expired = (wd_q == WD_LAST);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_idx_d  = win_idx_q;
        win_oh_d   = win_oh_q;
        seed_d     = seed_q;
        rnd_d      = rnd_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = err_q;

        if (seed_load && state_q != S_IDLE) begin
            pend_d     = sanitize_seed(seed_in);
            pend_vld_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    seed_d = sanitize_seed(seed_in);
                end else if (pend_vld_q) begin
                    seed_d = pend_q;
                end
                pend_vld_d = 1'b0;
                if (pick_any) begin
                    win_idx_d = pick_idx;
                    win_oh_d  = pick_oh;
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: begin
                state_d = S_START;
            end
            S_START: begin
                if (prng_done) begin
                    state_d = S_RELEASE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (!prng_done) begin
                    seed_d  = prng_rand;
                    rnd_d   = prng_rand;
                    state_d = S_DELIVER;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DELIVER: begin
                ptr_d   = (win_idx_q == PTR_W'(NREQ - 1)) ? '0 : win_idx_q + PTR_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog measures time spent in the current state only.
        wd_d = (state_d != state_q) ? '0 : wd_q + WD_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            win_idx_q  <= '0;
            win_oh_q   <= '0;
            seed_q     <= INIT_SEED;
            rnd_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_idx_q  <= win_idx_d;
            win_oh_q   <= win_oh_d;
            seed_q     <= seed_d;
            rnd_q      <= rnd_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
        end
    end

    assign ack         = (state_q == S_DELIVER) ? win_oh_q : '0;
    assign rnd_out     = rnd_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = err_q;
    assign prng_m      = MOD_M;
    assign prng_a      = MULT_A;
    assign prng_seed   = seed_q;
    assign prng_start  = (state_q == S_START);
    assign prng_cont   = 1'b0;

endmodule

// File: tb/tb_prng_scheduler.sv
// Self-checking bench for prng_scheduler with a behavioural Lehmer core and stream/arbiter model.
module tb_prng_scheduler;

    localparam int          NREQ    = 4;
    localparam int          WIDTH   = 32;
    localparam int          TIMEOUT = 1024;
    localparam logic [31:0] M       = 32'h7FFFFFFF;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] rnd_out;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             busy;
    logic             timeout_err;
    logic [WIDTH-1:0] prng_m, prng_a, prng_seed;
    logic             prng_start, prng_cont;
    logic             prng_done;
    logic [WIDTH-1:0] prng_rand;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_state;
    int          ref_ptr;

    bit core_stall;
    int core_lat;
    int core_cnt;

    prng_scheduler #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .INIT_SEED (32'd1),
        .MULT_A    (32'd16807),
        .MOD_M     (M),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .rnd_out     (rnd_out),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .busy        (busy),
        .timeout_err (timeout_err),
        .prng_m      (prng_m),
        .prng_a      (prng_a),
        .prng_seed   (prng_seed),
        .prng_start  (prng_start),
        .prng_cont   (prng_cont),
        .prng_done   (prng_done),
        .prng_rand   (prng_rand)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core: done rises a random few cycles after start, falls once start drops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prng_done <= 1'b0;
            prng_rand <= '0;
            core_cnt  <= 0;
            core_lat  <= 1;
        end else if (prng_start && !prng_done) begin
            if (!core_stall) begin
                if (core_cnt >= core_lat) begin
                    prng_done <= 1'b1;
                    prng_rand <= 32'((64'(prng_seed) * 64'd16807) % 64'(M));
                    core_cnt  <= 0;
                    core_lat  <= int'($urandom_range(0, 3));
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end
        end else if (!prng_start && prng_done) begin
            prng_done <= 1'b0;
        end
    end

    function automatic logic [31:0] lehmer(input logic [31:0] s);
        return 32'((64'(s) * 64'd16807) % 64'(M));
    endfunction

    function automatic logic [31:0] clamp_seed(input logic [31:0] s);
        return (s == 32'd0 || s >= M) ? 32'd1 : s;
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic apply_reset();
        rst        = 1'b1;
        req        = '0;
        seed_load  = 1'b0;
        seed_in    = '0;
        core_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        ref_state = 32'd1;
        ref_ptr   = 0;
    endtask

    task automatic wait_ack(output logic [3:0] a, output logic [31:0] v, output int cyc);
        a   = '0;
        v   = '0;
        cyc = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            cyc++;
            if (ack !== 4'b0) begin
                a = ack;
                v = rnd_out;
                break;
            end
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (prng_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] got  [9];
        logic [31:0] want [9];
        string       nm   [9];
        apply_reset();
        got[0] = 32'(ack);         want[0] = 32'd0;          nm[0] = "reset_ack";
        got[1] = rnd_out;          want[1] = 32'd0;          nm[1] = "reset_rnd_out";
        got[2] = 32'(busy);        want[2] = 32'd0;          nm[2] = "reset_busy";
        got[3] = 32'(prng_start);  want[3] = 32'd0;          nm[3] = "reset_prng_start";
        got[4] = 32'(timeout_err); want[4] = 32'd0;          nm[4] = "reset_timeout_err";
        got[5] = prng_seed;        want[5] = 32'd1;          nm[5] = "reset_prng_seed";
        got[6] = prng_a;           want[6] = 32'd16807;      nm[6] = "prng_a";
        got[7] = prng_m;           want[7] = 32'h7FFFFFFF;   nm[7] = "prng_m";
        got[8] = 32'(prng_cont);   want[8] = 32'd0;          nm[8] = "prng_cont";
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (got[i] !== want[i]) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_chain();
        logic [31:0] gold [3];
        logic [3:0]  a;
        logic [31:0] v, exp_v;
        int          cyc;
        gold[0] = 32'd16807;
        gold[1] = 32'd282475249;
        gold[2] = 32'd1622650073;
        apply_reset();
        @(negedge clk);
        req = 4'b0001;
        for (int t = 0; t < 3; t++) begin
            wait_ack(a, v, cyc);
            exp_v = lehmer(ref_state);
            if (t == 2) req = '0;
            n_vec++;
            if (a !== 4'b0001) begin
                n_err++;
                $display("FAIL chain_ack[%0d]: got %b expected 0001", t, a);
            end
            n_vec++;
            if (v !== exp_v || v !== gold[t]) begin
                n_err++;
                $display("FAIL chain_value[%0d]: got %0d expected %0d", t, v, gold[t]);
            end
            if (t == 0) begin
                n_vec++;
                if (cyc < 4) begin
                    n_err++;
                    $display("FAIL chain_latency: got %0d cycles expected >= 4", cyc);
                end
            end
            ref_state = exp_v;
            ref_ptr   = 1;
            @(negedge clk);
            n_vec++;
            if (ack !== 4'b0) begin
                n_err++;
                $display("FAIL chain_ack_pulse[%0d]: got %b expected 0000", t, ack);
            end
        end
    endtask

    task automatic test_golden();
        logic [3:0]  a;
        logic [31:0] v, exp_v;
        int          cyc;
        seed_load = 1'b1;
        seed_in   = 32'h7B818935;
        @(negedge clk);
        seed_load = 1'b0;
        ref_state = clamp_seed(32'h7B818935);
        req       = 4'b0100;
        wait_ack(a, v, cyc);
        req   = '0;
        exp_v = lehmer(ref_state);
        n_vec++;
        if (a !== 4'b0100) begin
            n_err++;
            $display("FAIL golden_ack: got %b expected 0100", a);
        end
        n_vec++;
        if (v !== 32'h755735EB || v !== exp_v) begin
            n_err++;
            $display("FAIL golden_value: got %h expected %h", v, 32'h755735EB);
        end
        ref_state = exp_v;
        ref_ptr   = 3;
    endtask

    task automatic test_round_robin();
        int          order [5];
        logic [3:0]  a, exp_oh;
        logic [31:0] v, exp_v;
        int          cyc, idx;
        order = '{0, 1, 2, 3, 0};
        apply_reset();
        @(negedge clk);
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_ack(a, v, cyc);
            if (t == 4) req = '0;
            idx    = rr_pick(4'b1111, ref_ptr);
            exp_oh = 4'(1 << idx);
            exp_v  = lehmer(ref_state);
            n_vec++;
            if (a !== exp_oh || a !== 4'(1 << order[t])) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got %b expected %b", t, a, 4'(1 << order[t]));
            end
            n_vec++;
            if (v !== exp_v) begin
                n_err++;
                $display("FAIL rr_value[%0d]: got %h expected %h", t, v, exp_v);
            end
            ref_state = exp_v;
            ref_ptr   = (idx + 1) % 4;
        end
    endtask

    task automatic test_reseed_busy();
        logic [3:0]  a;
        logic [31:0] v, exp_v;
        logic [31:0] loads [2];
        int          cyc;
        bit          ok;
        loads[0] = 32'h142E4ECE;
        loads[1] = 32'h0;
        req = 4'b0001;
        for (int r = 0; r < 2; r++) begin
            wait_start(ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL reseed_start_wait[%0d]: got no prng_start expected 1", r);
            end
            seed_load = 1'b1;
            seed_in   = loads[r];
            @(negedge clk);
            seed_load = 1'b0;
            for (int k = 0; k < 2; k++) begin
                wait_ack(a, v, cyc);
                if (r == 1 && k == 1) req = '0;
                exp_v = lehmer(ref_state);
                n_vec++;
                if (a !== 4'b0001 || v !== exp_v) begin
                    n_err++;
                    $display("FAIL reseed[%0d.%0d]: got ack %b val %h expected 0001 %h",
                             r, k, a, v, exp_v);
                end
                if (k == 1) begin
                    n_vec++;
                    if (v !== ((r == 0) ? 32'h6C37C0BB : 32'd16807)) begin
                        n_err++;
                        $display("FAIL reseed_const[%0d]: got %h expected %h", r, v,
                                 (r == 0) ? 32'h6C37C0BB : 32'd16807);
                    end
                end
                ref_state = (k == 0) ? clamp_seed(loads[r]) : exp_v;
                ref_ptr   = 1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  a, r, exp_oh;
        logic [31:0] v, exp_v, sv;
        int          cyc, idx;
        r   = 4'($urandom_range(1, 15));
        req = r;
        for (int t = 0; t < 20; t++) begin
            wait_ack(a, v, cyc);
            idx    = rr_pick(r, ref_ptr);
            exp_oh = 4'(1 << idx);
            exp_v  = lehmer(ref_state);
            n_vec++;
            if (a !== exp_oh || v !== exp_v) begin
                n_err++;
                $display("FAIL b2b[%0d]: got ack %b val %h expected %b %h", t, a, v, exp_oh, exp_v);
            end
            ref_state = exp_v;
            ref_ptr   = (idx + 1) % 4;
            r   = (t == 19) ? 4'b0 : 4'($urandom_range(1, 15));
            req = r;
            // A load landing with the ack is deferred to the next grant.
            if (t < 19 && $urandom_range(0, 2) == 0) begin
                sv        = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom();
                seed_load = 1'b1;
                seed_in   = sv;
                @(negedge clk);
                seed_load = 1'b0;
                ref_state = clamp_seed(sv);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0]  a, exp_oh;
        logic [31:0] v, exp_v;
        int          cyc, idx, waited;
        bit          ack_seen;
        core_stall = 1'b1;
        idx        = rr_pick(4'b1111, ref_ptr);
        exp_oh     = 4'(1 << idx);
        req        = 4'b1111;
        ack_seen   = 1'b0;
        waited     = 0;
        for (int c = 0; c < TIMEOUT + 50; c++) begin
            @(negedge clk);
            waited++;
            if (ack !== 4'b0) ack_seen = 1'b1;
            if (timeout_err === 1'b1) break;
        end
        n_vec++;
        if (timeout_err !== 1'b1 || waited < TIMEOUT) begin
            n_err++;
            $display("FAIL timeout_flag: got %b after %0d cycles expected 1 after >= %0d",
                     timeout_err, waited, TIMEOUT);
        end
        n_vec++;
        if (ack_seen !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_no_ack: got ack seen %b expected 0", ack_seen);
        end
        n_vec++;
        if (prng_start !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_start_drop: got %b expected 0", prng_start);
        end
        core_stall = 1'b0;
        wait_ack(a, v, cyc);
        req   = '0;
        exp_v = lehmer(ref_state);
        n_vec++;
        if (a !== exp_oh || v !== exp_v) begin
            n_err++;
            $display("FAIL timeout_regrant: got ack %b val %h expected %b %h", a, v, exp_oh, exp_v);
        end
        n_vec++;
        if (timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
        end
        ref_state = exp_v;
        ref_ptr   = (idx + 1) % 4;
    endtask

    task automatic test_async_reset();
        logic [3:0]  a;
        logic [31:0] v;
        int          cyc;
        bit          ok, fell;
        req = 4'b0001;
        wait_start(ok);
        fell = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (prng_start === 1'b0) begin
                fell = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!(ok && fell && busy === 1'b1)) begin
            n_err++;
            $display("FAIL arst_reach_release: got start_seen %b fell %b busy %b expected 1 1 1",
                     ok, fell, busy);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (ack !== 4'b0 || rnd_out !== 32'd0 || busy !== 1'b0 || prng_start !== 1'b0 ||
            timeout_err !== 1'b0 || prng_seed !== 32'd1) begin
            n_err++;
            $display("FAIL arst_outputs: got ack %b rnd %h busy %b start %b err %b seed %h expected all reset",
                     ack, rnd_out, busy, prng_start, timeout_err, prng_seed);
        end
        @(negedge clk);
        rst       = 1'b0;
        ref_state = 32'd1;
        ref_ptr   = 0;
        wait_ack(a, v, cyc);
        req = '0;
        n_vec++;
        if (a !== 4'b0001 || v !== lehmer(ref_state) || v !== 32'd16807) begin
            n_err++;
            $display("FAIL arst_restart: got ack %b val %0d expected 0001 16807", a, v);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        seed_load  = 1'b0;
        seed_in    = '0;
        core_stall = 1'b0;
        ref_state  = 32'd1;
        ref_ptr    = 0;
        test_reset();
        test_chain();
        test_golden();
        test_round_robin();
        test_reseed_busy();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
